// File: rtl/sram_port_arbiter.sv
// Two-port valid/ready arbiter in front of a single-port SRAM, with response routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed priority (port 1 first).
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    p0_valid_i,
  output logic                    p0_ready_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] p0_wmask_i,
  output logic                    p0_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   p0_rsp_rdata_o,
  input  logic                    p1_valid_i,
  output logic                    p1_ready_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] p1_wmask_i,
  output logic                    p1_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   p1_rsp_rdata_o,
  output logic                    sram_csb_o,
  output logic                    sram_web_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] sram_wmask_o,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH      = READ_LAT + 1;

  typedef struct packed {
    logic valid;
    logic port;
    logic is_write;
  } flight_t;

  logic                  grant1;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_WIDTH-1:0] sel_wmask;

  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  flight_t               flight_q [DEPTH];
  flight_t               flight_d [DEPTH];
  flight_t               tail;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;
`endif

  // grant1 selects port 1; it can only be set when port 1 is valid.
  always_comb begin
    grant1 = p1_valid_i;
`ifdef SRAM_ARB_RR_EN
    if (p0_valid_i && p1_valid_i) grant1 = ~last_q;
`endif
  end

  assign accept     = (p0_valid_i | p1_valid_i) & ~rst_i;
  assign p1_ready_o = p1_valid_i & grant1 & ~rst_i;
  assign p0_ready_o = p0_valid_i & ~grant1 & ~rst_i;

  assign sel_we    = grant1 ? p1_we_i    : p0_we_i;
  assign sel_addr  = grant1 ? p1_addr_i  : p0_addr_i;
  assign sel_wdata = grant1 ? p1_wdata_i : p0_wdata_i;
  assign sel_wmask = grant1 ? p1_wmask_i : p0_wmask_i;

  always_comb begin
    csb_d   = ~accept;
    web_d   = 1'b1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    if (accept) begin
      web_d   = ~sel_we;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      wmask_d = sel_we ? sel_wmask : '0;
    end
  end

`ifdef SRAM_ARB_RR_EN
  assign last_d = accept ? grant1 : last_q;
`endif

  assign flight_d[0] = '{valid: accept, port: grant1, is_write: sel_we};

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign flight_d[gi] = flight_q[gi-1];
    end
  endgenerate

  // The tail entry is live in the cycle sram_rdata_i carries its data.
  assign tail = flight_q[DEPTH-1];

  always_comb begin
    rsp0_valid_d = tail.valid & ~tail.port;
    rsp1_valid_d = tail.valid & tail.port;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (rsp0_valid_d) rsp0_rdata_d = tail.is_write ? '0 : sram_rdata_i;
    if (rsp1_valid_d) rsp1_rdata_d = tail.is_write ? '0 : sram_rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) flight_q[i] <= '0;
    end else begin
      csb_q        <= csb_d;
      web_q        <= web_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      for (int i = 0; i < DEPTH; i++) flight_q[i] <= flight_d[i];
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b0;
    else       last_q <= last_d;
  end
`endif

  assign sram_csb_o     = csb_q;
  assign sram_web_o     = web_q;
  assign sram_addr_o    = addr_q;
  assign sram_wdata_o   = wdata_q;
  assign sram_wmask_o   = wmask_q;
  assign p0_rsp_valid_o = rsp0_valid_q;
  assign p1_rsp_valid_o = rsp1_valid_q;
  assign p0_rsp_rdata_o = rsp0_rdata_q;
  assign p1_rsp_rdata_o = rsp1_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised + directed bench for sram_port_arbiter against a transaction-level model.
module tb_sram_port_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int RL = 1;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p0_valid = 0, p1_valid = 0, p0_we = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic [MW-1:0] p0_wmask = '0, p1_wmask = '0;
  logic p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid;
  logic [DW-1:0] p0_rsp_rdata, p1_rsp_rdata;
  logic sram_csb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [MW-1:0] sram_wmask;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(RL)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_valid_i(p0_valid), .p0_ready_o(p0_ready), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
    .p0_wdata_i(p0_wdata), .p0_wmask_i(p0_wmask), .p0_rsp_valid_o(p0_rsp_valid),
    .p0_rsp_rdata_o(p0_rsp_rdata),
    .p1_valid_i(p1_valid), .p1_ready_o(p1_ready), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
    .p1_wdata_i(p1_wdata), .p1_wmask_i(p1_wmask), .p1_rsp_valid_o(p1_rsp_valid),
    .p1_rsp_rdata_o(p1_rsp_rdata),
    .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata)
  );

  // Behavioural SRAM macro: registered read with RL cycles of latency.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [RL];
  assign sram_rdata = rd_pipe[RL-1];
  always @(posedge clk) begin
    rd_pipe[0] <= $urandom;
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < MW; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        rd_pipe[0] <= sram_mem[sram_addr];
      end
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model state
  typedef struct { logic port; logic [DW-1:0] data; int due; } rsp_t;
  rsp_t exp_q[$];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic model_last;
  logic exp_csb, exp_web;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [MW-1:0] exp_wmask;
  logic [DW-1:0] last_rd0, last_rd1;
  logic acc0, acc1;
  int cyc = 0;
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_last = 1'b0;
    exp_csb = 1'b1; exp_web = 1'b1;
    exp_addr = '0; exp_wdata = '0; exp_wmask = '0;
    last_rd0 = '0; last_rd1 = '0;
  endtask

  // One clock cycle: check DUT against model at the negedge, then advance the model.
  task automatic cycle();
    logic g1, acc, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [MW-1:0] wm;
    rsp_t r;
    @(negedge clk);
    acc = p0_valid | p1_valid;
    if (p0_valid && p1_valid) g1 = RR ? ~model_last : 1'b1;
    else g1 = p1_valid;
    check("p0_ready", p0_ready, p0_valid && !g1);
    check("p1_ready", p1_ready, p1_valid && g1);
    check("csb", sram_csb, exp_csb);
    check("web", sram_web, exp_web);
    check("addr", sram_addr, exp_addr);
    check("wdata", sram_wdata, exp_wdata);
    check("wmask", sram_wmask, exp_wmask);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      check("rsp_valid", {p1_rsp_valid, p0_rsp_valid}, r.port ? 2'b10 : 2'b01);
      check("rsp_rdata", r.port ? p1_rsp_rdata : p0_rsp_rdata, r.data);
      $display("cycle %0d: response port %0d data %08h", cyc, r.port, r.data);
      if (r.port) last_rd1 = r.data; else last_rd0 = r.data;
    end else begin
      check("rsp_idle", {p1_rsp_valid, p0_rsp_valid}, 2'b00);
      check("p0_rdata_hold", p0_rsp_rdata, last_rd0);
      check("p1_rdata_hold", p1_rsp_rdata, last_rd1);
    end
    acc0 = acc && !g1;
    acc1 = acc && g1;
    if (acc) begin
      we = g1 ? p1_we : p0_we;
      a  = g1 ? p1_addr : p0_addr;
      wd = g1 ? p1_wdata : p0_wdata;
      wm = g1 ? p1_wmask : p0_wmask;
      rd = we ? '0 : model_mem[a];
      if (we)
        for (int b = 0; b < MW; b++) if (wm[b]) model_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      exp_q.push_back('{port: g1, data: rd, due: cyc + RL + 2});
      exp_csb = 1'b0; exp_web = ~we; exp_addr = a; exp_wdata = wd;
      exp_wmask = we ? wm : '0;
      model_last = g1;
    end else begin
      exp_csb = 1'b1; exp_web = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = $urandom;
      model_mem[i] = sram_mem[i];
    end
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
    sram_mem[16'h0010] = 32'hDEADBEEF;
    model_mem[16'h0010] = 32'hDEADBEEF;
    for (int i = 1; i <= 3; i++) begin
      sram_mem[i] = 32'h1111_0000 * i;
      model_mem[i] = sram_mem[i];
    end
    model_reset();
    acc0 = 0; acc1 = 0;

    // Reset, then idle
    repeat (3) cycle();
    rst = 1'b0;
    repeat (10) cycle();

    // p0 read of 0x0010
    p0_valid = 1; p0_we = 0; p0_addr = 13'h0010;
    cycle();
    p0_valid = 0;
    repeat (4) cycle();

    // p1 write to the top address
    p1_valid = 1; p1_we = 1; p1_addr = 13'h1FFF; p1_wdata = 32'hA5A5A5A5; p1_wmask = 4'b0011;
    cycle();
    p1_valid = 0;
    repeat (4) cycle();

    // Both ports hold reads; each port advances its address only when accepted
    p0_valid = 1; p0_we = 0; p0_addr = 13'h0100;
    p1_valid = 1; p1_we = 0; p1_addr = 13'h0200;
    repeat (4) begin
      cycle();
      if (acc0) p0_addr = p0_addr + 1'b1;
      if (acc1) p1_addr = p1_addr + 1'b1;
    end
    p0_valid = 0; p1_valid = 0;
    repeat (5) cycle();

    // Back-to-back p0 reads
    p0_valid = 1; p0_we = 0;
    for (int i = 1; i <= 3; i++) begin
      p0_addr = AW'(i);
      cycle();
    end
    p0_valid = 0;
    repeat (5) cycle();

    // Random traffic on a small address window to exercise read-after-write ordering
    for (int n = 0; n < 1500; n++) begin
      if (!p0_valid || acc0) begin
        p0_valid = ($urandom_range(0, 3) != 0);
        p0_we = 1'($urandom_range(0, 1)); p0_addr = AW'($urandom_range(0, 31));
        p0_wdata = $urandom; p0_wmask = MW'($urandom_range(0, 15));
      end
      if (!p1_valid || acc1) begin
        p1_valid = ($urandom_range(0, 2) != 0);
        p1_we = 1'($urandom_range(0, 1)); p1_addr = AW'($urandom_range(0, 31));
        p1_wdata = $urandom; p1_wmask = MW'($urandom_range(0, 15));
      end
      cycle();
    end
    p0_valid = 0; p1_valid = 0;
    repeat (6) cycle();

    // Two reads in flight, then reset one cycle later
    p0_valid = 1; p0_we = 0; p0_addr = 13'h0002;
    cycle();
    p0_addr = 13'h0003;
    cycle();
    p1_valid = 1; p1_we = 0;
    rst = 1'b1;
    #1;
    check("rst_csb", sram_csb, 1'b1);
    check("rst_p0_ready", p0_ready, 1'b0);
    check("rst_p1_ready", p1_ready, 1'b0);
    p0_valid = 0; p1_valid = 0;
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (8) cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
